// File: rtl/dmem_bus_pkg.sv
// Shared types and widths for the data-memory bus responder.
package dmem_bus_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // One load/store request as seen at the accept handshake, plus its address check.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
    logic            err;
  } req_t;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module dmem_byte_ram
  import dmem_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [BE_W-1:0]                be,
  input  logic [XLEN-1:0]                wdata,
  output logic [XLEN-1:0]                rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Array contents survive reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BE_W); b++) begin
      if (we && be[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_bus_responder.sv
// Data-memory responder: valid/ready request channel, programmable access latency,
// and a valid/ready response channel carrying load data or a store acknowledgement.
module dmem_bus_responder
  import dmem_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  state_e            state_q, state_nxt;
  logic [LAT_W-1:0]  cnt_q, cnt_nxt;
  req_t              cap_q, live_c, cmt_c;
  logic              accept_c, commit_c;
  logic              rsp_valid_nxt, rsp_err_nxt;
  logic [XLEN-1:0]   rsp_rdata_nxt;
  logic [XLEN-1:0]   ram_rdata;

  // Below-base addresses wrap to a large offset, so one unsigned compare covers both ends.
  assign live_c = '{
    we:    req_we,
    addr:  req_addr,
    wdata: req_wdata,
    be:    req_be,
    err:   (req_addr[1:0] != 2'b00) || ((req_addr - BASE_ADDR) >= XLEN'(4 * DEPTH_WORDS))
  };

  // With zero latency the commit happens on the accept edge, before the capture is visible.
  assign cmt_c = (state_q == IDLE) ? live_c : cap_q;

  dmem_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit_c && cmt_c.we && !cmt_c.err),
    .re    (commit_c && !cmt_c.we && !cmt_c.err),
    .idx   (AW'((cmt_c.addr - BASE_ADDR) >> 2)),
    .be    (cmt_c.be),
    .wdata (cmt_c.wdata),
    .rdata (ram_rdata)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      if (accept_c) begin
        cap_q <= live_c;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_nxt = (LATENCY > 0) ? WAIT : RESP;
      WAIT:    if (cnt_q == '0) state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, commit strobe and response register next values. The RAM read lands one
  // edge after the commit, so the response registers load on the first RESP cycle.
  always_comb begin
    accept_c      = 1'b0;
    commit_c      = 1'b0;
    cnt_nxt       = cnt_q;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          cnt_nxt  = LAT_LOAD;
          commit_c = (LATENCY == 0);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit_c = 1'b1;
        end else begin
          cnt_nxt = cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (!rsp_valid) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = (cap_q.err || cap_q.we) ? '0 : ram_rdata;
          rsp_err_nxt   = cap_q.err;
        end else if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
        end
      end
      default: begin
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench for dmem_bus_responder: two instances (latency 2 and 0) against a transaction-level model.
module tb_dmem_bus_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [31:0] req_addr  [2] = '{32'h0, 32'h0};
  logic [31:0] req_wdata [2] = '{32'h0, 32'h0};
  logic [3:0]  req_be    [2] = '{4'h0, 4'h0};
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic void timeout(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endfunction

  function automatic bit bad_addr(logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a - BASE) >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : 0;

    dmem_bus_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .BASE_ADDR   (BASE)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );

    // Model: one transaction in flight; memory changes LAT edges after accept,
    // the response becomes visible one edge later and stays until taken.
    logic [31:0] mm [DEPTH];
    bit          mk [DEPTH];
    bit          pend = 0, vis = 0, known = 0;
    int          t = 0;
    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic [31:0] exp_rdata = 0;
    logic        exp_err = 0;

    task automatic commit(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
      int i;
      i = int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
      if (bad_addr(a)) begin
        exp_err <= 1'b1; exp_rdata <= '0; known <= 1'b1;
      end else if (we) begin
        exp_err <= 1'b0; exp_rdata <= '0; known <= 1'b1;
        for (int b = 0; b < 4; b++) if (be[b]) mm[i][8*b +: 8] <= wd[8*b +: 8];
        if (be == 4'hF) mk[i] <= 1'b1;
      end else begin
        exp_err <= 1'b0; exp_rdata <= mm[i]; known <= mk[i];
      end
    endtask

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend <= 0; vis <= 0; t <= 0;
      end else if (pend && vis) begin
        if (rsp_ready[g]) begin pend <= 0; vis <= 0; end
      end else if (pend) begin
        t <= t + 1;
        if (t + 1 == int'(LAT)) commit(c_we, c_addr, c_wdata, c_be);
        if (t + 1 == int'(LAT) + 1) vis <= 1;
      end else if (req_valid[g]) begin
        pend <= 1; t <= 0;
        c_we <= req_we[g]; c_addr <= req_addr[g]; c_wdata <= req_wdata[g]; c_be <= req_be[g];
        if (LAT == 0) commit(req_we[g], req_addr[g], req_wdata[g], req_be[g]);
      end
    end

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
      if (!rst_n) begin
        check($sformatf("dut%0d reset rsp_valid", g), 32'(rsp_valid[g]), 32'd0);
        check($sformatf("dut%0d reset rsp_rdata", g), rsp_rdata[g], 32'd0);
        check($sformatf("dut%0d reset rsp_err", g), 32'(rsp_err[g]), 32'd0);
      end else begin
        check($sformatf("dut%0d req_ready", g), 32'(req_ready[g]), 32'(!pend));
        check($sformatf("dut%0d rsp_valid", g), 32'(rsp_valid[g]), 32'(vis));
        if (vis) begin
          check($sformatf("dut%0d rsp_err", g), 32'(rsp_err[g]), 32'(exp_err));
          if (known) check($sformatf("dut%0d rsp_rdata", g), rsp_rdata[g], exp_rdata);
        end else begin
          check($sformatf("dut%0d idle rsp_rdata", g), rsp_rdata[g], 32'd0);
          check($sformatf("dut%0d idle rsp_err", g), 32'(rsp_err[g]), 32'd0);
        end
      end
    end
  end

  // One request/response; k>0 withholds rsp_ready for k cycles once the response shows.
  task automatic xact(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int k,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout($sformatf("dut%0d accept", d));
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_we[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    req_be[d] = 4'($urandom);
    if (k > 0) rsp_ready[d] = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rsp_valid[d] && lat < 40);
    if (lat >= 40) timeout($sformatf("dut%0d response", d));
    rd = rsp_rdata[d];
    er = rsp_err[d];
    if (k > 0) begin
      repeat (k) @(negedge clk);
      rsp_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        er, we;
    int          lat, k, r, n;
    int          acc [4];

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset req_ready dut0", 32'(req_ready[0]), 32'd1);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) xact(d, 1'b1, 32'(4 * i), init_word(i), 4'hF, 0, rd, er, lat);

    // Full-word store then load, with latency pinned by hand.
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    check("t1 store latency", 32'(lat), 32'd3);
    check("t1 store err", 32'(er), 32'd0);
    check("t1 store rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("t1 load rdata", rd, 32'hDEAD_BEEF);

    // Partial byte-enable store over all-ones.
    xact(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    xact(0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 0, rd, er, lat);
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
    check("t2 merged rdata", rd, 32'hFF22_FF44);
    xact(0, 1'b1, 32'h24, 32'h5555_5555, 4'b0000, 0, rd, er, lat);
    check("t2 be0 store err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h24, 32'h0, 4'hF, 0, rd, er, lat);
    check("t2 be0 untouched", rd, init_word(9));

    // Misaligned and out-of-range accesses.
    xact(0, 1'b0, 32'h13, 32'h0, 4'hF, 0, rd, er, lat);
    check("t3 misaligned err", 32'(er), 32'd1);
    check("t3 misaligned rdata", rd, 32'd0);
    xact(0, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 0, rd, er, lat);
    check("t3 range err", 32'(er), 32'd1);
    check("t3 range rdata", rd, 32'd0);
    check("t3 range latency", 32'(lat), 32'd3);
    xact(0, 1'b1, 32'h13, 32'h0BAD_0BAD, 4'hF, 0, rd, er, lat);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat);
    check("t3 word 0x10 kept", rd, 32'hDEAD_BEEF);

    // Backpressure: held response, then IDLE on the release edge.
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat);
    check("t4 held rdata", rd, 32'hDEAD_BEEF);
    check("t4 req_ready after release", 32'(req_ready[0]), 32'd1);

    // Reset while a store waits: the store is dropped.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
    req_wdata[0] = 32'h1234_5678; req_be[0] = 4'hF;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("t5 accept");
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5 rsp_valid in reset", 32'(rsp_valid[0]), 32'd0);
    check("t5 rsp_rdata in reset", rsp_rdata[0], 32'd0);
    check("t5 rsp_err in reset", 32'(rsp_err[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xact(0, 1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er, lat);
    check("t5 old value", rd, init_word(12));

    // Zero latency: single-transaction latency and back-to-back spacing.
    xact(1, 1'b0, 32'h08, 32'h0, 4'hF, 0, rd, er, lat);
    check("t6 lat0 latency", 32'(lat), 32'd1);
    check("t6 lat0 rdata", rd, init_word(2));
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_be[1] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_addr[1] = 32'(4 * i);
      n = 0;
      while (!req_ready[1] && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("t6 accept");
      @(posedge clk); #1;
      acc[i] = cyc;
    end
    req_valid[1] = 1'b0;
    for (int i = 1; i < 4; i++) check($sformatf("t6 spacing %0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
    repeat (5) @(negedge clk);

    // Random traffic with occasional backpressure, errors and partial stores.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 80; i++) begin
        r  = $urandom_range(0, 9);
        we = 1'($urandom);
        wd = $urandom;
        if (r < 8)       a = 32'(4 * $urandom_range(0, 63));
        else if (r == 8) a = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
        else             a = (i % 2 == 1) ? 32'h400 + 32'(4 * $urandom_range(0, 255)) : 32'hFFFF_FFFC;
        k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        xact(d, we, a, wd, 4'($urandom), k, rd, er, lat);
        check($sformatf("rand dut%0d err", d), 32'(er), 32'(bad_addr(a)));
      end
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
